spi_slave_core: RTL and testbench

Native SPI slave that is the other end of the team's SPI master link. It is clocked by the system clock and oversamples SCLK, SS_N and MOSI through synchronisers. Received bytes are delivered as single-cycle strobes, and transmit bytes are taken through a valid/ready holding register. It sits on the board-facing SPI pins and feeds a control/LED front-end, mirroring how the master side is used.

---
 rtl/spi_slave_core_pkg.sv | 17 +
 rtl/spi_slave_core_sync_edge.sv | 34 +++
 rtl/spi_slave_core.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_core_pkg.sv
// Shared constants and types for the SPI slave core: word size, default transmit
// word, clock-mode encodings and the frame state machine encoding.
package spi_slave_core_pkg;

   localparam int         SPI_DATA_WIDTH = 8;
   localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

   localparam bit SPI_CPOL_IDLE_LOW = 1'b0;
   localparam bit SPI_CPHA_LEADING  = 1'b0;
   localparam bit SPI_CPHA_TRAILING = 1'b1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third flop for edge
// detection; rise/fall pulses are valid for one cycle, one edge before they are acted on.
module spi_sync_edge #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   // [0] first stage, [1] synchronised level, [2] previous synchronised level
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   always_comb begin
      sync_d = {sync_q[1:0], async_i};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its pre-edge inputs regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {3{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign rise_o =  sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave oversampled by the system clock: receives words as single-cycle strobes
// and transmits from a one-word valid/ready holding register, with underrun/abort flags.
module spi_slave_core
   import spi_slave_core_pkg::*;
#(
   parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
   parameter bit                    CPOL       = 1'b0,
   parameter bit                    CPHA       = 1'b0,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = DATA_WIDTH'(SPI_DEFAULT_TX)
) (
   input  logic                  I_CLK,
   input  logic                  I_RESETN,
   input  logic                  SCLK_SLAVE,
   input  logic                  SS_N_SLAVE,
   input  logic                  MOSI_SLAVE,
   output logic                  MISO_SLAVE,
   output logic                  O_MISO_OE,
   input  logic [DATA_WIDTH-1:0] I_TX_DATA,
   input  logic                  I_TX_VALID,
   output logic                  O_TX_READY,
   output logic [DATA_WIDTH-1:0] O_RX_DATA,
   output logic                  O_RX_VALID,
   output logic                  O_TX_UNDERRUN,
   output logic                  O_ABORT,
   output logic                  O_BUSY
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic sclk_rise;
   logic sclk_fall;
   logic ss_rise;
   logic ss_fall;
   logic mosi_sync;
   logic lead_edge;
   logic trail_edge;
   logic sample_edge;
   logic shift_edge;

   spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
      .clk    (I_CLK),
      .rst_n  (I_RESETN),
      .async_i(SCLK_SLAVE),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
      .clk    (I_CLK),
      .rst_n  (I_RESETN),
      .async_i(SS_N_SLAVE),
      .rise_o (ss_rise),
      .fall_o (ss_fall)
   );

   // MOSI needs no edge detect; its two stages keep it aligned with the SCLK events
   logic [1:0] mosi_sync_q;
   logic [1:0] mosi_sync_d;

   always_comb begin
      mosi_sync_d = {mosi_sync_q[0], MOSI_SLAVE};
   end

   assign mosi_sync   = mosi_sync_q[1];
   assign lead_edge   = (CPOL == SPI_CPOL_IDLE_LOW) ? sclk_rise : sclk_fall;
   assign trail_edge  = (CPOL == SPI_CPOL_IDLE_LOW) ? sclk_fall : sclk_rise;
   assign sample_edge = (CPHA == SPI_CPHA_TRAILING) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA == SPI_CPHA_LEADING)  ? trail_edge : lead_edge;

   spi_state_e            state_q,     state_d;
   logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [DATA_WIDTH-2:0] rx_shift_q,  rx_shift_d;
   logic [DATA_WIDTH-2:0] tx_shift_q,  tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
   logic [DATA_WIDTH-1:0] hold_q,      hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  miso_q,      miso_d;
   logic                  oe_q,        oe_d;
   logic                  busy_q,      busy_d;
   logic                  rx_valid_q,  rx_valid_d;
   logic                  underrun_q,  underrun_d;
   logic                  abort_q,     abort_d;
   logic                  skip_q,      skip_d;

   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] load_word;
   logic                  load;
   logic                  capture;

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      rx_data_d   = rx_data_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      busy_d      = busy_q;
      skip_d      = skip_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      abort_d     = 1'b0;
      load        = 1'b0;
      rx_word     = {rx_shift_q, mosi_sync};
      load_word   = hold_full_q ? hold_q : DEFAULT_TX;
      capture     = I_TX_VALID & ~hold_full_q;

      case (state_q)
         ST_IDLE: begin
            if (ss_fall) begin
               state_d   = ST_ACTIVE;
               load      = 1'b1;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               oe_d      = 1'b1;
               // with CPHA=1 the first leading edge would shift away the MSB just loaded
               skip_d    = (CPHA == SPI_CPHA_TRAILING);
            end
         end
         ST_ACTIVE: begin
            if (ss_rise) begin
               abort_d   = (bit_cnt_q != '0);
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               busy_d    = 1'b0;
               oe_d      = 1'b0;
               miso_d    = 1'b1;
               skip_d    = 1'b0;
            end else if (sample_edge) begin
               if (bit_cnt_q == LAST_BIT) begin
                  rx_data_d  = rx_word;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  load       = 1'b1;
                  // the reload already presents the next MSB, so the next shift edge is a no-op
                  skip_d     = 1'b1;
               end else begin
                  rx_shift_d = rx_word[DATA_WIDTH-2:0];
                  bit_cnt_d  = bit_cnt_q + 1'b1;
               end
            end else if (shift_edge) begin
               if (skip_q) begin
                  skip_d = 1'b0;
               end else begin
                  miso_d     = tx_shift_q[DATA_WIDTH-2];
                  tx_shift_d = tx_shift_q << 1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         miso_d     = load_word[DATA_WIDTH-1];
         tx_shift_d = load_word[DATA_WIDTH-2:0];
         underrun_d = ~hold_full_q;
      end

      // a load in the same cycle as a capture sees the register still empty
      if (capture) begin
         hold_d      = I_TX_DATA;
         hold_full_d = 1'b1;
      end else if (load && hold_full_q) begin
         hold_full_d = 1'b0;
      end
   end

   // NOTE: the data registers (shifters, holding word, received word) are reset
   // too, so a mid-frame reset leaves nothing stale to leak into the next frame.
   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         mosi_sync_q <= 2'b00;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         rx_data_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         miso_q      <= 1'b1;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         abort_q     <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rx_data_q   <= rx_data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         abort_q     <= abort_d;
         skip_q      <= skip_d;
      end
   end

   assign MISO_SLAVE    = miso_q;
   assign O_MISO_OE     = oe_q;
   assign O_TX_READY    = ~hold_full_q;
   assign O_RX_DATA     = rx_data_q;
   assign O_RX_VALID    = rx_valid_q;
   assign O_TX_UNDERRUN = underrun_q;
   assign O_ABORT       = abort_q;
   assign O_BUSY        = busy_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: a mode-0 slave and a CPOL=1/CPHA=1 slave driven by a behavioural
// master with SCLK = I_CLK/8; strobes are counted by a negedge monitor.
module tb_spi_slave_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sclk = 2'b10;
   logic [1:0] ss_n = 2'b11;
   logic [1:0] mosi = 2'b00;
   logic [1:0] tx_valid = 2'b00;
   logic [7:0] tx_data [2] = '{8'h00, 8'h00};

   logic [1:0] miso;
   logic [1:0] miso_oe;
   logic [1:0] tx_ready;
   logic [1:0] rx_valid;
   logic [1:0] underrun;
   logic [1:0] abort_s;
   logic [1:0] busy;
   logic [7:0] rx_data [2];

   int total = 0;
   int bad = 0;

   int         rxv_cnt [2] = '{0, 0};
   int         und_cnt [2] = '{0, 0};
   int         abt_cnt [2] = '{0, 0};
   logic [7:0] rx_last [2] = '{8'h00, 8'h00};
   logic [7:0] rx_hist0 [$];

   always #5 clk = ~clk;

   spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) u_m0 (
      .I_CLK        (clk),
      .I_RESETN     (rst_n),
      .SCLK_SLAVE   (sclk[0]),
      .SS_N_SLAVE   (ss_n[0]),
      .MOSI_SLAVE   (mosi[0]),
      .MISO_SLAVE   (miso[0]),
      .O_MISO_OE    (miso_oe[0]),
      .I_TX_DATA    (tx_data[0]),
      .I_TX_VALID   (tx_valid[0]),
      .O_TX_READY   (tx_ready[0]),
      .O_RX_DATA    (rx_data[0]),
      .O_RX_VALID   (rx_valid[0]),
      .O_TX_UNDERRUN(underrun[0]),
      .O_ABORT      (abort_s[0]),
      .O_BUSY       (busy[0])
   );

   spi_slave_core #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) u_m3 (
      .I_CLK        (clk),
      .I_RESETN     (rst_n),
      .SCLK_SLAVE   (sclk[1]),
      .SS_N_SLAVE   (ss_n[1]),
      .MOSI_SLAVE   (mosi[1]),
      .MISO_SLAVE   (miso[1]),
      .O_MISO_OE    (miso_oe[1]),
      .I_TX_DATA    (tx_data[1]),
      .I_TX_VALID   (tx_valid[1]),
      .O_TX_READY   (tx_ready[1]),
      .O_RX_DATA    (rx_data[1]),
      .O_RX_VALID   (rx_valid[1]),
      .O_TX_UNDERRUN(underrun[1]),
      .O_ABORT      (abort_s[1]),
      .O_BUSY       (busy[1])
   );

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rx_valid[k] === 1'b1) begin
            rxv_cnt[k]++;
            rx_last[k] = rx_data[k];
         end
         if (underrun[k] === 1'b1) und_cnt[k]++;
         if (abort_s[k] === 1'b1) abt_cnt[k]++;
      end
      if (rx_valid[0] === 1'b1) rx_hist0.push_back(rx_data[0]);
   end

   task automatic write_tx(input int k, input logic [7:0] d);
      @(negedge clk);
      tx_data[k]  = d;
      tx_valid[k] = 1'b1;
      @(negedge clk);
      tx_valid[k] = 1'b0;
   endtask

   // mode-0 master: bits from_bit down to to_bit; MISO captured just before each rising edge
   task automatic m0_bits(input logic [7:0] tx, input int from_bit, input int to_bit,
                          inout logic [7:0] cap);
      for (int i = from_bit; i >= to_bit; i--) begin
         mosi[0] = tx[i];
         #40;
         cap = {cap[6:0], miso[0]};
         sclk[0] = 1'b1;
         #40;
         sclk[0] = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         total++; if (miso[k] !== 1'b1) begin bad++; $display("FAIL reset_miso[%0d]: got %b want 1", k, miso[k]); end
         total++; if (miso_oe[k] !== 1'b0) begin bad++; $display("FAIL reset_oe[%0d]: got %b want 0", k, miso_oe[k]); end
         total++; if (tx_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", k, tx_ready[k]); end
         total++; if (rx_data[k] !== 8'h00) begin bad++; $display("FAIL reset_rx_data[%0d]: got %h want 00", k, rx_data[k]); end
         total++; if ({rx_valid[k], underrun[k], abort_s[k], busy[k]} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes[%0d]: got %b want 0000", k, {rx_valid[k], underrun[k], abort_s[k], busy[k]});
         end
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_mode0_basic();
      logic [7:0] cap = 8'h00;
      int u0, r0;
      write_tx(0, 8'h3C);
      total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL basic_ready_full: got %b want 0", tx_ready[0]); end
      u0 = und_cnt[0]; r0 = rxv_cnt[0];
      ss_n[0] = 1'b0;
      #80;
      total++; if ({busy[0], miso_oe[0]} !== 2'b11) begin bad++; $display("FAIL basic_busy_oe: got %b want 11", {busy[0], miso_oe[0]}); end
      total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL basic_ready_after_load: got %b want 1", tx_ready[0]); end
      total++; if (und_cnt[0] - u0 !== 0) begin bad++; $display("FAIL basic_no_underrun: got %0d want 0", und_cnt[0] - u0); end
      m0_bits(8'hA5, 7, 0, cap);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (rxv_cnt[0] - r0 !== 1) begin bad++; $display("FAIL basic_rx_strobes: got %0d want 1", rxv_cnt[0] - r0); end
      total++; if (rx_last[0] !== 8'hA5) begin bad++; $display("FAIL basic_rx_word: got %h want a5", rx_last[0]); end
      total++; if (rx_data[0] !== 8'hA5) begin bad++; $display("FAIL basic_rx_hold: got %h want a5", rx_data[0]); end
      total++; if (cap !== 8'h3C) begin bad++; $display("FAIL basic_miso_word: got %h want 3c", cap); end
      total++; if ({busy[0], miso_oe[0], miso[0]} !== 3'b001) begin
         bad++; $display("FAIL basic_idle_after: got %b want 001", {busy[0], miso_oe[0], miso[0]});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cap1 = 8'h00;
      logic [7:0] cap2 = 8'h00;
      int u0, r0, h0;
      write_tx(0, 8'hC3);
      u0 = und_cnt[0]; r0 = rxv_cnt[0]; h0 = rx_hist0.size();
      ss_n[0] = 1'b0;
      #80;
      fork
         m0_bits(8'h12, 7, 0, cap1);
         begin
            #200;
            write_tx(0, 8'h5A);
         end
      join
      m0_bits(8'h34, 7, 1, cap2);
      total++; if (und_cnt[0] - u0 !== 0) begin bad++; $display("FAIL b2b_no_underrun: got %0d want 0", und_cnt[0] - u0); end
      m0_bits(8'h34, 0, 0, cap2);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (rxv_cnt[0] - r0 !== 2) begin bad++; $display("FAIL b2b_rx_strobes: got %0d want 2", rxv_cnt[0] - r0); end
      if (rx_hist0.size() >= h0 + 2) begin
         total++; if (rx_hist0[h0] !== 8'h12) begin bad++; $display("FAIL b2b_rx_first: got %h want 12", rx_hist0[h0]); end
         total++; if (rx_hist0[h0 + 1] !== 8'h34) begin bad++; $display("FAIL b2b_rx_second: got %h want 34", rx_hist0[h0 + 1]); end
      end else begin
         total++; bad++; $display("FAIL b2b_rx_count: got %0d words want 2", rx_hist0.size() - h0);
      end
      total++; if (cap1 !== 8'hC3) begin bad++; $display("FAIL b2b_miso_first: got %h want c3", cap1); end
      total++; if (cap2 !== 8'h5A) begin bad++; $display("FAIL b2b_miso_second: got %h want 5a", cap2); end
   endtask

   task automatic test_underrun();
      logic [7:0] cap = 8'h00;
      int u0;
      total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL und_ready_empty: got %b want 1", tx_ready[0]); end
      u0 = und_cnt[0];
      ss_n[0] = 1'b0;
      #80;
      total++; if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL und_pulse_at_fall: got %0d want 1", und_cnt[0] - u0); end
      m0_bits(8'h00, 7, 1, cap);
      total++; if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL und_single_pulse: got %0d want 1", und_cnt[0] - u0); end
      m0_bits(8'h00, 0, 0, cap);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (cap !== 8'hFF) begin bad++; $display("FAIL und_miso_default: got %h want ff", cap); end
      total++; if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL und_rx_word: got %h want 00", rx_data[0]); end
   endtask

   task automatic test_abort();
      logic [7:0] cap = 8'h00;
      int a0, r0;
      a0 = abt_cnt[0]; r0 = rxv_cnt[0];
      ss_n[0] = 1'b0;
      #80;
      m0_bits(8'hFF, 7, 3, cap);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (abt_cnt[0] - a0 !== 1) begin bad++; $display("FAIL abort_pulse: got %0d want 1", abt_cnt[0] - a0); end
      total++; if (rxv_cnt[0] - r0 !== 0) begin bad++; $display("FAIL abort_no_rx: got %0d want 0", rxv_cnt[0] - r0); end
      total++; if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL abort_rx_kept: got %h want 00", rx_data[0]); end
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy[0]); end
      ss_n[0] = 1'b0;
      #80;
      m0_bits(8'h81, 7, 0, cap);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (rx_data[0] !== 8'h81) begin bad++; $display("FAIL abort_next_frame: got %h want 81", rx_data[0]); end
      total++; if (rxv_cnt[0] - r0 !== 1) begin bad++; $display("FAIL abort_next_strobe: got %0d want 1", rxv_cnt[0] - r0); end
      total++; if (abt_cnt[0] - a0 !== 1) begin bad++; $display("FAIL abort_full_no_abort: got %0d want 1", abt_cnt[0] - a0); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] cap = 8'h00;
      int a0, r0, u0;
      ss_n[0] = 1'b0;
      #80;
      write_tx(0, 8'h11);
      m0_bits(8'hE7, 7, 5, cap);
      #20;
      a0 = abt_cnt[0]; r0 = rxv_cnt[0]; u0 = und_cnt[0];
      rst_n = 1'b0;
      #1;
      total++; if ({miso[0], miso_oe[0], busy[0], tx_ready[0]} !== 4'b1001) begin
         bad++; $display("FAIL midrst_outputs: got %b want 1001", {miso[0], miso_oe[0], busy[0], tx_ready[0]});
      end
      total++; if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL midrst_rx_data: got %h want 00", rx_data[0]); end
      total++; if ({rx_valid[0], underrun[0], abort_s[0]} !== 3'b000) begin
         bad++; $display("FAIL midrst_strobes: got %b want 000", {rx_valid[0], underrun[0], abort_s[0]});
      end
      #9;
      ss_n[0] = 1'b1;
      #50;
      rst_n = 1'b1;
      #100;
      total++; if ((abt_cnt[0] - a0) + (rxv_cnt[0] - r0) + (und_cnt[0] - u0) !== 0) begin
         bad++; $display("FAIL midrst_no_strobes: got %0d want 0", (abt_cnt[0] - a0) + (rxv_cnt[0] - r0) + (und_cnt[0] - u0));
      end
      ss_n[0] = 1'b0;
      #80;
      m0_bits(8'h7E, 7, 0, cap);
      #40;
      ss_n[0] = 1'b1;
      #100;
      total++; if (rx_data[0] !== 8'h7E) begin bad++; $display("FAIL midrst_next_frame: got %h want 7e", rx_data[0]); end
      total++; if (cap !== 8'hFF) begin bad++; $display("FAIL midrst_hold_lost: got %h want ff", cap); end
   endtask

   task automatic test_mode3();
      logic [7:0] cap = 8'h00;
      logic [7:0] tx_m = 8'h69;
      logic [7:0] exp_m = 8'h96;
      int r1, u1;
      write_tx(1, 8'h96);
      r1 = rxv_cnt[1]; u1 = und_cnt[1];
      ss_n[1] = 1'b0;
      #80;
      total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL m3_busy: got %b want 1", busy[1]); end
      for (int i = 7; i >= 0; i--) begin
         sclk[1] = 1'b0;
         mosi[1] = tx_m[i];
         #40;
         total++; if (miso[1] !== exp_m[i]) begin bad++; $display("FAIL m3_bit%0d: got %b want %b", i, miso[1], exp_m[i]); end
         cap = {cap[6:0], miso[1]};
         sclk[1] = 1'b1;
         #40;
      end
      #40;
      ss_n[1] = 1'b1;
      #100;
      total++; if (rx_data[1] !== 8'h69) begin bad++; $display("FAIL m3_rx_word: got %h want 69", rx_data[1]); end
      total++; if (rxv_cnt[1] - r1 !== 1) begin bad++; $display("FAIL m3_rx_strobes: got %0d want 1", rxv_cnt[1] - r1); end
      total++; if (cap !== 8'h96) begin bad++; $display("FAIL m3_miso_word: got %h want 96", cap); end
      total++; if (tx_ready[1] !== 1'b1) begin bad++; $display("FAIL m3_ready: got %b want 1", tx_ready[1]); end
      total++; if (und_cnt[1] - u1 !== 1) begin bad++; $display("FAIL m3_end_reload_underrun: got %0d want 1", und_cnt[1] - u1); end
   endtask

   initial begin
      test_reset();
      test_mode0_basic();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid_frame();
      test_mode3();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
